// File: rtl/fp_to_fixed.sv
// fp_to_fixed: sequential IEEE-754 single -> signed fixed-point converter.
// Aligns the 24-bit significand one bit per clock, then truncates (or rounds),
// negates and saturates into an OUT_W-bit word with overflow/invalid flags.
// Optional build macro FP_TO_FIXED_ROUND_EN: round-half-to-even instead of
// truncation toward zero.
module fp_to_fixed #(
   parameter int unsigned OUT_W     = 32,
   parameter int unsigned FRAC_BITS = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      A_FP,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] result,
   output logic             overflow,
   output logic             invalid,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned SR_W  = (OUT_W > 25) ? OUT_W : 25;
   localparam int unsigned CNT_W = 5;
   localparam logic signed [9:0] FRAC_S  = 10'(FRAC_BITS);
   localparam logic signed [9:0] MAX_EXP = 10'(OUT_W - 2);
   localparam logic signed [9:0] MIN_EXP = 10'(OUT_W - 1);
   localparam logic [OUT_W-1:0]  POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]  NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};
`ifdef FP_TO_FIXED_ROUND_EN
   localparam logic [SR_W:0]     RND_LIM = (SR_W+1)'(1) << (OUT_W - 1);
`endif

   typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_FINISH, S_DONE} state_t;

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   result_q, result_d;
   logic               overflow_q, overflow_d;
   logic               invalid_q, invalid_d;
   logic               sign_q, sign_d;
   logic               sat_q, sat_d;
   logic               sat_ovf_q, sat_ovf_d;
   logic               nan_q, nan_d;
   logic               left_q, left_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SR_W-1:0]    sr_q, sr_d;
`ifdef FP_TO_FIXED_ROUND_EN
   logic               guard_q, guard_d;
   logic               sticky_q, sticky_d;
   logic               round_up;
   logic [SR_W:0]      mag_ext;
`endif

   logic               a_sign;
   logic [7:0]         a_exp;
   logic [22:0]        a_frac;
   logic signed [9:0]  exp_unb;
   logic signed [9:0]  k;
   logic signed [9:0]  neg_k;
   logic [CNT_W-1:0]   shift_n;
   logic [OUT_W-1:0]   mag_o;
   logic               rnd_ovf;

   // Operand decode: unbiased exponent (with fraction offset) and shift amount
   always_comb begin
      a_sign  = A_FP[31];
      a_exp   = A_FP[30:23];
      a_frac  = A_FP[22:0];
      exp_unb = $signed({2'b00, a_exp}) - 10'sd127 + FRAC_S;
      k       = exp_unb - 10'sd23;
      neg_k   = -k;
      if (k >= 10'sd0) begin
         shift_n = k[CNT_W-1:0];
      end else if (neg_k > 10'sd25) begin
         shift_n = CNT_W'(25);
      end else begin
         shift_n = neg_k[CNT_W-1:0];
      end
   end

   // Aligned magnitude for the FINISH step, with optional rounding
   always_comb begin
`ifdef FP_TO_FIXED_ROUND_EN
      round_up = guard_q & (sticky_q | sr_q[0]);
      mag_ext  = {1'b0, sr_q} + (SR_W+1)'(round_up);
      rnd_ovf  = (mag_ext >= RND_LIM);
      mag_o    = OUT_W'(mag_ext);
`else
      rnd_ovf  = 1'b0;
      mag_o    = OUT_W'(sr_q);
`endif
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      in_ready_d  = 1'b0;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      overflow_d  = overflow_q;
      invalid_d   = invalid_q;
      sign_d      = sign_q;
      sat_d       = sat_q;
      sat_ovf_d   = sat_ovf_q;
      nan_d       = nan_q;
      left_d      = left_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
`ifdef FP_TO_FIXED_ROUND_EN
      guard_d     = guard_q;
      sticky_d    = sticky_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            if (in_valid && in_ready_q) begin
               in_ready_d = 1'b0;
               sign_d     = a_sign;
               sat_d      = 1'b0;
               sat_ovf_d  = 1'b0;
               nan_d      = 1'b0;
               left_d     = (k >= 10'sd0);
               cnt_d      = '0;
               sr_d       = SR_W'({1'b1, a_frac});
`ifdef FP_TO_FIXED_ROUND_EN
               guard_d    = 1'b0;
               sticky_d   = 1'b0;
`endif
               if (a_exp == 8'd0) begin
                  sr_d = '0;
               end else if (a_exp == 8'hFF) begin
                  sr_d = '0;
                  if (a_frac != 23'd0) begin
                     nan_d = 1'b1;
                  end else begin
                     sat_d     = 1'b1;
                     sat_ovf_d = 1'b1;
                  end
               end else if (exp_unb > MAX_EXP) begin
                  // -2^(OUT_W-1) is representable, so it is not an overflow
                  sr_d      = '0;
                  sat_d     = 1'b1;
                  sat_ovf_d = !(a_sign && (a_frac == 23'd0) && (exp_unb == MIN_EXP));
               end else begin
                  cnt_d = shift_n;
               end
               state_d = (cnt_d != '0) ? S_ALIGN : S_FINISH;
            end
         end

         S_ALIGN: begin
            if (left_q) begin
               sr_d = sr_q << 1;
            end else begin
               sr_d = sr_q >> 1;
`ifdef FP_TO_FIXED_ROUND_EN
               guard_d  = sr_q[0];
               sticky_d = sticky_q | guard_q;
`endif
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FINISH;
            end
         end

         S_FINISH: begin
            overflow_d = 1'b0;
            invalid_d  = 1'b0;
            if (nan_q) begin
               result_d  = '0;
               invalid_d = 1'b1;
            end else if (sat_q || rnd_ovf) begin
               result_d   = sign_q ? NEG_MAX : POS_MAX;
               overflow_d = sat_q ? sat_ovf_q : 1'b1;
            end else begin
               result_d = sign_q ? (~mag_o + OUT_W'(1)) : mag_o;
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         invalid_q   <= 1'b0;
         sign_q      <= 1'b0;
         sat_q       <= 1'b0;
         sat_ovf_q   <= 1'b0;
         nan_q       <= 1'b0;
         left_q      <= 1'b0;
         cnt_q       <= '0;
         sr_q        <= '0;
`ifdef FP_TO_FIXED_ROUND_EN
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         invalid_q   <= invalid_d;
         sign_q      <= sign_d;
         sat_q       <= sat_d;
         sat_ovf_q   <= sat_ovf_d;
         nan_q       <= nan_d;
         left_q      <= left_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
`ifdef FP_TO_FIXED_ROUND_EN
         guard_q     <= guard_d;
         sticky_q    <= sticky_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign invalid   = invalid_q;

endmodule

// File: tb/tb_fp_to_fixed.sv
// Directed bench for fp_to_fixed: default instance (OUT_W=32, FRAC_BITS=0)
// plus a FRAC_BITS=8 instance. Expectations follow FP_TO_FIXED_ROUND_EN.
module tb_fp_to_fixed;

`ifdef FP_TO_FIXED_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic [31:0] a_fp, a_fp8;
   logic        in_valid, in_valid8;
   logic        in_ready, in_ready8;
   logic [31:0] result, result8;
   logic        overflow, overflow8;
   logic        invalid, invalid8;
   logic        out_valid, out_valid8;
   logic        out_ready, out_ready8;

   int checks = 0;
   int errors = 0;

   fp_to_fixed #(.OUT_W(32), .FRAC_BITS(0)) dut (
      .clock(clock), .reset(reset), .A_FP(a_fp), .in_valid(in_valid),
      .in_ready(in_ready), .result(result), .overflow(overflow),
      .invalid(invalid), .out_valid(out_valid), .out_ready(out_ready)
   );

   fp_to_fixed #(.OUT_W(32), .FRAC_BITS(8)) dut8 (
      .clock(clock), .reset(reset), .A_FP(a_fp8), .in_valid(in_valid8),
      .in_ready(in_ready8), .result(result8), .overflow(overflow8),
      .invalid(invalid8), .out_valid(out_valid8), .out_ready(out_ready8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One conversion: capture, count edges until out_valid, then handshake
   task automatic convert(input bit use8, input logic [31:0] a,
                          output logic [31:0] r, output logic o,
                          output logic i, output int lat);
      int w;
      w = 0;
      while (!(use8 ? in_ready8 : in_ready) && w < 200) begin
         @(posedge clock); #1; w++;
      end
      if (use8) begin a_fp8 = a; in_valid8 = 1'b1; end
      else begin a_fp = a; in_valid = 1'b1; end
      @(posedge clock); #1;
      in_valid = 1'b0; in_valid8 = 1'b0;
      a_fp = $urandom(); a_fp8 = $urandom();
      lat = 0;
      while (!(use8 ? out_valid8 : out_valid) && lat < 200) begin
         @(posedge clock); #1; lat++;
      end
      r = use8 ? result8 : result;
      o = use8 ? overflow8 : overflow;
      i = use8 ? invalid8 : invalid;
      if (use8) out_ready8 = 1'b1; else out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0; out_ready8 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      checks++;
      if (result !== 32'd0 || overflow !== 1'b0 || invalid !== 1'b0 ||
          out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset got res=%h ovf=%b inv=%b ov=%b ir=%b exp 0 0 0 0 1",
                  result, overflow, invalid, out_valid, in_ready);
      end
   endtask

   task automatic test_align();
      logic [31:0] va [10];
      logic [31:0] vr [10];
      int          vl [10];
      logic [31:0] r;
      logic        o, i;
      int          lat;
      va = '{32'h40490FDB, 32'hC0200000, 32'h3FE00000, 32'h4E800000, 32'hCE800000,
             32'h4B000001, 32'h3F400000, 32'h3E800000, 32'hC2F70000, 32'h00800000};
      vr = '{32'd3, 32'hFFFFFFFE, RND ? 32'd2 : 32'd1, 32'h40000000, 32'hC0000000,
             32'd8388609, RND ? 32'd1 : 32'd0, 32'd0,
             RND ? 32'hFFFFFF84 : 32'hFFFFFF85, 32'd0};
      vl = '{24, 24, 25, 9, 9, 2, 26, 27, 19, 27};
      for (int n = 0; n < 10; n++) begin
         convert(1'b0, va[n], r, o, i, lat);
         checks++;
         if (r !== vr[n]) begin
            errors++;
            $display("FAIL align[%0d] a=%h result got %h exp %h", n, va[n], r, vr[n]);
         end
         checks++;
         if (o !== 1'b0 || i !== 1'b0) begin
            errors++;
            $display("FAIL align_flags[%0d] got ovf=%b inv=%b exp 0 0", n, o, i);
         end
         checks++;
         if (lat !== vl[n]) begin
            errors++;
            $display("FAIL align_lat[%0d] got %0d exp %0d", n, lat, vl[n]);
         end
      end
   endtask

   task automatic test_special();
      logic [31:0] va [9];
      logic [31:0] vr [9];
      logic        vo [9];
      logic        vi [9];
      logic [31:0] r;
      logic        o, i;
      int          lat;
      va = '{32'h4F000000, 32'hCF000000, 32'h7F800000, 32'h7FC00000, 32'hFF800000,
             32'h80000000, 32'h00000001, 32'hCF000001, 32'hFFC00000};
      vr = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'h80000000,
             32'd0, 32'd0, 32'h80000000, 32'd0};
      vo = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vi = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int n = 0; n < 9; n++) begin
         convert(1'b0, va[n], r, o, i, lat);
         checks++;
         if (r !== vr[n] || o !== vo[n] || i !== vi[n]) begin
            errors++;
            $display("FAIL special[%0d] a=%h got %h/%b/%b exp %h/%b/%b",
                     n, va[n], r, o, i, vr[n], vo[n], vi[n]);
         end
         checks++;
         if (lat !== 2) begin
            errors++;
            $display("FAIL special_lat[%0d] got %0d exp 2", n, lat);
         end
      end
   endtask

   task automatic test_frac_bits();
      logic [31:0] va [4];
      logic [31:0] vr [4];
      logic        vo [4];
      int          vl [4];
      logic [31:0] r;
      logic        o, i;
      int          lat;
      va = '{32'h3FC00000, 32'hBFA00000, 32'h4A800000, 32'h4B000000};
      vr = '{32'h00000180, 32'hFFFFFEC0, 32'h40000000, 32'h7FFFFFFF};
      vo = '{1'b0, 1'b0, 1'b0, 1'b1};
      vl = '{17, 17, 9, 2};
      for (int n = 0; n < 4; n++) begin
         convert(1'b1, va[n], r, o, i, lat);
         checks++;
         if (r !== vr[n] || o !== vo[n] || i !== 1'b0 || lat !== vl[n]) begin
            errors++;
            $display("FAIL frac8[%0d] a=%h got %h/%b/%b lat %0d exp %h/%b/0 lat %0d",
                     n, va[n], r, o, i, lat, vr[n], vo[n], vl[n]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int w;
      w = 0;
      while (!in_ready && w < 200) begin @(posedge clock); #1; w++; end
      a_fp = 32'h40490FDB; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 200) begin @(posedge clock); #1; w++; end
      // offer 5.0 while the result is stalled
      a_fp = 32'h40A00000; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock); #1;
         checks++;
         if (result !== 32'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall[%0d] got res=%h ov=%b ir=%b exp 3 1 0",
                     c, result, out_valid, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL release got ov=%b ir=%b exp 0 0", out_valid, in_ready);
      end
      @(posedge clock); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reaccept got ir=%b ov=%b exp 1 0", in_ready, out_valid);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      a_fp = 32'h3F800000;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL capture_ready got %b exp 0", in_ready);
      end
      lat = 0;
      while (!out_valid && lat < 200) begin @(posedge clock); #1; lat++; end
      checks++;
      if (result !== 32'd5 || lat !== 23) begin
         errors++;
         $display("FAIL next_op got %h lat %0d exp 5 lat 23", result, lat);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_align();
      logic [31:0] r;
      logic        o, i;
      int          lat;
      int          seen;
      int          w;
      w = 0;
      while (!in_ready && w < 200) begin @(posedge clock); #1; w++; end
      a_fp = 32'h40490FDB; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (5) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 ||
          overflow !== 1'b0 || invalid !== 1'b0) begin
         errors++;
         $display("FAIL abort got ov=%b ir=%b res=%h ovf=%b inv=%b exp 0 1 0 0 0",
                  out_valid, in_ready, result, overflow, invalid);
      end
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clock); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_quiet got %0d valid cycles exp 0", seen);
      end
      convert(1'b0, 32'h40000000, r, o, i, lat);
      checks++;
      if (r !== 32'd2 || o !== 1'b0 || i !== 1'b0 || lat !== 24) begin
         errors++;
         $display("FAIL after_abort got %h/%b/%b lat %0d exp 2/0/0 lat 24", r, o, i, lat);
      end
   endtask

   initial begin
      reset = 1'b1;
      a_fp = '0; a_fp8 = '0;
      in_valid = 1'b0; in_valid8 = 1'b0;
      out_ready = 1'b0; out_ready8 = 1'b0;
      #1;
      test_reset();
      test_align();
      test_special();
      test_frac_bits();
      test_back_to_back();
      test_reset_mid_align();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
